// File: rtl/cbf_block_rmw_engine.sv
// Read-modify-write engine for one counting-Bloom-filter block store (query / insert / delete).
// Latency from request accept to respValid: 4 cycles for query, 5 for insert/delete (1-cycle memory).
// Backpressure: one request in flight; reqReady low until the cycle after the response handshake.
module cbf_block_rmw_engine #(
    parameter int NUM_HASHES                 = 6,
    parameter int VECTOR_WIDTH               = 1024,
    parameter int NUM_BITS_TO_ADDRESS_VECTOR = 10,
    parameter int CBF_WIDTH                  = 4,
    parameter int BLOCK_ADDR_WIDTH           = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           reqValid,
    output logic                                           reqReady,
    input  logic [1:0]                                     reqOp,
    input  logic [BLOCK_ADDR_WIDTH-1:0]                    reqBlockAddr,
    input  logic [NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES-1:0] reqHashes,
    output logic                                           memRdEn,
    output logic [BLOCK_ADDR_WIDTH-1:0]                    memRdAddr,
    input  logic                                           memRdValid,
    input  logic [CBF_WIDTH*VECTOR_WIDTH-1:0]              memRdData,
    output logic                                           memWrEn,
    output logic [BLOCK_ADDR_WIDTH-1:0]                    memWrAddr,
    output logic [CBF_WIDTH*VECTOR_WIDTH-1:0]              memWrData,
    output logic                                           respValid,
    input  logic                                           respReady,
    output logic                                           respPresent,
    output logic [CBF_WIDTH-1:0]                           respMinCount,
    output logic [CBF_WIDTH*NUM_HASHES-1:0]                respElements
);

    localparam int BLK_W  = CBF_WIDTH * VECTOR_WIDTH;
    localparam int NB     = NUM_BITS_TO_ADDRESS_VECTOR;
    localparam int HASH_W = NB * NUM_HASHES;
    localparam int ELEM_W = CBF_WIDTH * NUM_HASHES;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;

    // All-ones entry value: saturated, never incremented or decremented.
    localparam logic [CBF_WIDTH-1:0] ENTRY_MAX = '1;

    logic [2:0]                  r_state;
    logic [1:0]                  r_op;
    logic [BLOCK_ADDR_WIDTH-1:0] r_addr;
    logic [HASH_W-1:0]           r_hashes;
    logic [BLK_W-1:0]            r_blk;
    logic [BLK_W-1:0]            r_wr_data;
    logic [ELEM_W-1:0]           r_resp_elems;
    logic [CBF_WIDTH-1:0]        r_resp_min;
    logic                        r_resp_present;

    logic [ELEM_W-1:0]           w_elems;
    logic [VECTOR_WIDTH-1:0]     w_hit;
    logic [CBF_WIDTH-1:0]        w_min;
    logic                        w_present;
    logic [BLK_W-1:0]            w_new_blk;
    logic [CBF_WIDTH-1:0]        w_entry;
    logic                        w_is_write;

    assign w_is_write = (r_op == OP_INSERT) || (r_op == OP_DELETE);

    // Pick the entry addressed by each hash and mark which entries are hit;
    // an out-of-range index reads as 0 and hits nothing. Duplicates hit once.
    always_comb begin
        w_elems = '0;
        w_hit   = '0;
        for (int h = 0; h < NUM_HASHES; h++) begin
            if (int'(r_hashes[h*NB +: NB]) < VECTOR_WIDTH) begin
                w_elems[h*CBF_WIDTH +: CBF_WIDTH] =
                    r_blk[int'(r_hashes[h*NB +: NB])*CBF_WIDTH +: CBF_WIDTH];
                w_hit[int'(r_hashes[h*NB +: NB])] = 1'b1;
            end
        end
    end

    // Minimum and membership over the selected (pre-op) entries.
    always_comb begin
        w_min     = ENTRY_MAX;
        w_present = 1'b1;
        for (int h = 0; h < NUM_HASHES; h++) begin
            if (w_elems[h*CBF_WIDTH +: CBF_WIDTH] < w_min) begin
                w_min = w_elems[h*CBF_WIDTH +: CBF_WIDTH];
            end
            if (w_elems[h*CBF_WIDTH +: CBF_WIDTH] == '0) begin
                w_present = 1'b0;
            end
        end
    end

    // Build the modified block: saturating increment on insert, decrement on
    // delete with saturated entries sticky. With 1-bit entries this reduces to
    // OR on insert and no change on delete.
    always_comb begin
        w_new_blk = r_blk;
        w_entry   = '0;
        for (int j = 0; j < VECTOR_WIDTH; j++) begin
            w_entry = r_blk[j*CBF_WIDTH +: CBF_WIDTH];
            if (w_hit[j]) begin
                if (r_op == OP_INSERT) begin
                    if (w_entry != ENTRY_MAX) begin
                        w_new_blk[j*CBF_WIDTH +: CBF_WIDTH] = w_entry + 1'b1;
                    end
                end else if (r_op == OP_DELETE) begin
                    if ((w_entry != '0) && (w_entry != ENTRY_MAX)) begin
                        w_new_blk[j*CBF_WIDTH +: CBF_WIDTH] = w_entry - 1'b1;
                    end
                end
            end
        end
    end

    // Request sequencing: accept, read, wait for data, compute, optional write-back, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_addr         <= '0;
            r_hashes       <= '0;
            r_blk          <= '0;
            r_wr_data      <= '0;
            r_resp_elems   <= '0;
            r_resp_min     <= '0;
            r_resp_present <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_op     <= reqOp;
                        r_addr   <= reqBlockAddr;
                        r_hashes <= reqHashes;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (memRdValid) begin
                        r_blk   <= memRdData;
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_resp_elems   <= w_elems;
                    r_resp_min     <= w_min;
                    r_resp_present <= w_present;
                    r_wr_data      <= w_new_blk;
                    r_state        <= w_is_write ? S_WRITE : S_RESP;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (respReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and handshakes decode straight from state registers, so
    // reqReady never depends combinationally on respReady.
    assign reqReady     = (r_state == S_IDLE);
    assign memRdEn      = (r_state == S_READ);
    assign memRdAddr    = r_addr;
    assign memWrEn      = (r_state == S_WRITE);
    assign memWrAddr    = r_addr;
    assign memWrData    = r_wr_data;
    assign respValid    = (r_state == S_RESP);
    assign respPresent  = r_resp_present;
    assign respMinCount = r_resp_min;
    assign respElements = r_resp_elems;

endmodule

// File: tb/tb_cbf_block_rmw_engine.sv
// Bench for cbf_block_rmw_engine: block-memory responder, high-level model and per-cycle checker.
// Latency measured from accepting cycle to first respValid cycle.
// Response backpressure applied by holding respReady low for a programmable number of cycles.
module tb_cbf_block_rmw_engine;

    localparam int NH   = 6;
    localparam int VW   = 1024;
    localparam int NB   = 10;
    localparam int CW   = 4;
    localparam int AW   = 8;
    localparam int W    = CW * VW;
    localparam int HW   = NB * NH;
    localparam int EW   = CW * NH;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [1:0]    reqOp = 2'b00;
    logic [AW-1:0] reqBlockAddr = '0;
    logic [HW-1:0] reqHashes = '0;
    logic          memRdEn;
    logic [AW-1:0] memRdAddr;
    logic          memRdValid = 1'b0;
    logic [W-1:0]  memRdData = '0;
    logic          memWrEn;
    logic [AW-1:0] memWrAddr;
    logic [W-1:0]  memWrData;
    logic          respValid;
    logic          respReady = 1'b0;
    logic          respPresent;
    logic [CW-1:0] respMinCount;
    logic [EW-1:0] respElements;

    cbf_block_rmw_engine #(
        .NUM_HASHES(NH), .VECTOR_WIDTH(VW), .NUM_BITS_TO_ADDRESS_VECTOR(NB),
        .CBF_WIDTH(CW), .BLOCK_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqBlockAddr(reqBlockAddr), .reqHashes(reqHashes),
        .memRdEn(memRdEn), .memRdAddr(memRdAddr), .memRdValid(memRdValid), .memRdData(memRdData),
        .memWrEn(memWrEn), .memWrAddr(memWrAddr), .memWrData(memWrData),
        .respValid(respValid), .respReady(respReady), .respPresent(respPresent),
        .respMinCount(respMinCount), .respElements(respElements)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Block memory as seen by the DUT, and the model's view of what it should hold.
    logic [W-1:0] mem     [0:255];
    logic [W-1:0] ref_mem [0:255];

    // Expectations for the request in flight.
    logic          exp_wr = 1'b0;
    logic          quiet = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0]  exp_new = '0;
    logic [EW-1:0] exp_elems = '0;
    logic [CW-1:0] exp_min = '0;
    logic          exp_pres = 1'b0;
    int            wr_cnt = 0;
    int            mem_lat = 1;
    logic          prev_hs = 1'b0;

    // Results of the most recent response, for literal pinning.
    int            last_lat = 0;
    logic [CW-1:0] last_min = '0;
    logic          last_pres = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        int  first;
        logic found;
        checks++;
        if (act !== req) begin
            errors++;
            first = 0;
            found = 1'b0;
            for (int j = 0; j < VW; j++) begin
                if (!found && (act[j*CW +: CW] !== req[j*CW +: CW])) begin
                    first = j;
                    found = 1'b1;
                end
            end
            $display("FAIL %s entry %0d actual=%0h required=%0h", nm, first,
                     act[first*CW +: CW], req[first*CW +: CW]);
        end
    endtask

    function automatic int entry_of(input logic [W-1:0] b, input int j);
        return int'(b[j*CW +: CW]);
    endfunction

    function automatic logic [HW-1:0] pack6(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        int v [NH];
        logic [HW-1:0] r;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e; v[5] = f;
        r = '0;
        for (int i = 0; i < NH; i++) r[i*NB +: NB] = NB'(v[i]);
        return r;
    endfunction

    // Counting Bloom filter semantics: gather the distinct set of hit entries,
    // report pre-op values, then bump each hit entry once with saturation.
    function automatic void model(input logic [W-1:0] b, input logic [1:0] op,
                                  input logic [HW-1:0] hs, output logic [W-1:0] nb,
                                  output logic [EW-1:0] el, output logic [CW-1:0] mn,
                                  output logic pr);
        int idx_list [$];
        int mnv;
        int v;
        int idx;
        mnv = MAXV;
        pr  = 1'b1;
        el  = '0;
        nb  = b;
        for (int h = 0; h < NH; h++) begin
            idx = int'(hs[h*NB +: NB]);
            v   = (idx < VW) ? entry_of(b, idx) : 0;
            el[h*CW +: CW] = CW'(v);
            if (v < mnv) mnv = v;
            if (v == 0) pr = 1'b0;
            if (idx < VW) begin
                int dup [$];
                dup = idx_list.find(x) with (x == idx);
                if (dup.size() == 0) idx_list.push_back(idx);
            end
        end
        mn = CW'(mnv);
        foreach (idx_list[k]) begin
            v = entry_of(b, idx_list[k]);
            if (op == 2'b01 && v < MAXV) v = v + 1;
            else if (op == 2'b10 && v > 0 && v < MAXV) v = v - 1;
            nb[idx_list[k]*CW +: CW] = CW'(v);
        end
    endfunction

    task automatic set_entry(input int addr, input int j, input int v);
        mem[addr][j*CW +: CW]     = CW'(v);
        ref_mem[addr][j*CW +: CW] = CW'(v);
    endtask

    // Block memory: returns data mem_lat cycles after a read strobe, applies writes.
    int            rd_cnt = 0;
    logic [AW-1:0] rd_addr = '0;
    always @(posedge clk) begin
        #1;
        memRdValid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin
                memRdValid = 1'b1;
                memRdData  = mem[rd_addr];
            end
        end
        if (memRdEn) begin
            rd_addr = memRdAddr;
            rd_cnt  = mem_lat;
        end
        if (memWrEn) mem[memWrAddr] = memWrData;
    end

    // Per-cycle checker against the model's expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memWrEn) begin
                wr_cnt = wr_cnt + 1;
                chk("wr_allowed", {63'd0, exp_wr && !quiet}, 64'd1);
                chk("wr_addr", {56'd0, memWrAddr}, {56'd0, exp_addr});
                chk_blk("wr_data", memWrData, exp_new);
            end
            if (respValid) begin
                chk("resp_allowed", {63'd0, !quiet}, 64'd1);
                chk("resp_elements", {40'd0, respElements}, {40'd0, exp_elems});
                chk("resp_min", {60'd0, respMinCount}, {60'd0, exp_min});
                chk("resp_present", {63'd0, respPresent}, {63'd0, exp_pres});
                chk("req_ready_while_resp", {63'd0, reqReady}, 64'd0);
            end
            if (prev_hs) chk("req_ready_after_hs", {63'd0, reqReady}, 64'd1);
            prev_hs = respValid && respReady;
        end else begin
            prev_hs = 1'b0;
        end
    end

    task automatic do_req(input logic [1:0] op, input int addr, input logic [HW-1:0] hs,
                          input int lat, input int hold);
        int   acc;
        int   rc;
        logic got;
        logic [W-1:0] nb;
        logic [EW-1:0] el;
        logic [CW-1:0] mn;
        logic pr;
        model(ref_mem[addr], op, hs, nb, el, mn, pr);
        exp_new   = nb;
        exp_elems = el;
        exp_min   = mn;
        exp_pres  = pr;
        exp_wr    = (op == 2'b01) || (op == 2'b10);
        exp_addr  = AW'(addr);
        wr_cnt    = 0;
        mem_lat   = lat;
        acc       = 0;
        rc        = 0;
        @(posedge clk); #1;
        reqValid     = 1'b1;
        reqOp        = op;
        reqBlockAddr = AW'(addr);
        reqHashes    = hs;
        respReady    = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (reqReady) begin got = 1'b1; acc = cyc; end
        end
        chk("req_accepted", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (respValid) begin got = 1'b1; rc = cyc; end
        end
        chk("resp_arrived", {63'd0, got}, 64'd1);
        if (got) begin
            last_lat  = rc - acc;
            last_min  = respMinCount;
            last_pres = respPresent;
            chk("latency", 64'(last_lat), 64'((exp_wr ? 5 : 4) + lat - 1));
            chk("write_before_resp", 64'(wr_cnt), exp_wr ? 64'd1 : 64'd0);
            if (hold > 0) begin
                repeat (hold) @(posedge clk);
                #1;
                chk("resp_held_valid", {63'd0, respValid}, 64'd1);
                chk("req_ready_held_low", {63'd0, reqReady}, 64'd0);
                respReady = 1'b1;
            end
            @(posedge clk); #1;
            respReady = 1'b0;
            chk("req_ready_after_resp", {63'd0, reqReady}, 64'd1);
            chk("resp_cleared", {63'd0, respValid}, 64'd0);
        end
        if (exp_wr) ref_mem[addr] = exp_new;
        chk("write_count", 64'(wr_cnt), exp_wr ? 64'd1 : 64'd0);
    endtask

    logic [W-1:0] saved;
    logic         got_acc;

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, reqReady}, 64'd1);
        chk("rst_mem_rd_en", {63'd0, memRdEn}, 64'd0);
        chk("rst_mem_wr_en", {63'd0, memWrEn}, 64'd0);
        chk("rst_resp_valid", {63'd0, respValid}, 64'd0);
        chk("rst_rd_addr", {56'd0, memRdAddr}, 64'd0);
        chk("rst_min", {60'd0, respMinCount}, 64'd0);
        chk_blk("rst_wr_data", memWrData, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Insert into an empty block with a duplicate hash.
        do_req(2'b01, 5, pack6(3, 3, 7, 0, 1, 2), 1, 0);
        chk("ins_e3", 64'(entry_of(mem[5], 3)), 64'd1);
        chk("ins_e7", 64'(entry_of(mem[5], 7)), 64'd1);
        chk("ins_e0", 64'(entry_of(mem[5], 0)), 64'd1);
        chk("ins_e4", 64'(entry_of(mem[5], 4)), 64'd0);
        chk("ins_present", {63'd0, last_pres}, 64'd0);
        chk("ins_min", {60'd0, last_min}, 64'd0);

        // Query of the entries just set.
        do_req(2'b00, 5, pack6(0, 1, 2, 3, 7, 7), 1, 0);
        chk("qry_present", {63'd0, last_pres}, 64'd1);
        chk("qry_min", {60'd0, last_min}, 64'd1);
        chk("qry_latency", 64'(last_lat), 64'd4);

        // Saturated entry stays sticky; unsaturated one goes up then down.
        set_entry(5, 9, 15);
        set_entry(5, 4, 2);
        do_req(2'b01, 5, pack6(9, 4, 9, 4, 9, 4), 1, 0);
        chk("sat_ins_e9", 64'(entry_of(mem[5], 9)), 64'd15);
        chk("sat_ins_e4", 64'(entry_of(mem[5], 4)), 64'd3);
        chk("sat_ins_min", {60'd0, last_min}, 64'd2);
        chk("ins_latency", 64'(last_lat), 64'd5);
        do_req(2'b10, 5, pack6(9, 4, 9, 4, 9, 4), 1, 0);
        chk("sat_del_e9", 64'(entry_of(mem[5], 9)), 64'd15);
        chk("sat_del_e4", 64'(entry_of(mem[5], 4)), 64'd2);
        chk("sat_del_min", {60'd0, last_min}, 64'd3);

        // Delete down to zero and on an already-zero entry.
        do_req(2'b10, 5, pack6(0, 6, 0, 6, 1, 1), 1, 0);
        chk("del_e0", 64'(entry_of(mem[5], 0)), 64'd0);
        chk("del_e6", 64'(entry_of(mem[5], 6)), 64'd0);
        chk("del_e1", 64'(entry_of(mem[5], 1)), 64'd0);

        // Op 11 behaves as query; slow memory and held-off response.
        do_req(2'b11, 5, pack6(9, 4, 3, 7, 2, 9), 5, 3);
        chk("slow_latency", 64'(last_lat), 64'd8);
        chk("slow_min", {60'd0, last_min}, 64'd1);

        // Random block contents, boundary indices.
        for (int k = 0; k < W / 32; k++) begin
            mem[9][k*32 +: 32] = $urandom;
        end
        ref_mem[9] = mem[9];
        set_entry(9, 100, 15);
        set_entry(9, 1023, 0);
        set_entry(9, 512, 1);
        do_req(2'b01, 9, pack6(100, 1023, 512, 100, 7, 0), 2, 1);
        chk("rnd_e1023", 64'(entry_of(mem[9], 1023)), 64'd1);
        do_req(2'b10, 9, pack6(100, 1023, 512, 512, 7, 0), 3, 2);
        chk("rnd_e100", 64'(entry_of(mem[9], 100)), 64'd15);
        chk("rnd_e512", 64'(entry_of(mem[9], 512)), 64'd1);

        // Reset while waiting for read data during an insert.
        for (int k = 0; k < W / 32; k++) begin
            mem[7][k*32 +: 32] = $urandom;
        end
        ref_mem[7] = mem[7];
        saved   = mem[7];
        quiet   = 1'b1;
        exp_wr  = 1'b0;
        mem_lat = 5;
        @(posedge clk); #1;
        reqValid     = 1'b1;
        reqOp        = 2'b01;
        reqBlockAddr = 8'd7;
        reqHashes    = pack6(1, 2, 3, 4, 5, 6);
        got_acc = 1'b0;
        for (int i = 0; i < 50 && !got_acc; i++) begin
            @(negedge clk);
            if (reqReady) got_acc = 1'b1;
        end
        chk("abort_req_accepted", {63'd0, got_acc}, 64'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", {63'd0, reqReady}, 64'd1);
        chk("abort_wr_en", {63'd0, memWrEn}, 64'd0);
        chk("abort_resp_valid", {63'd0, respValid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        quiet = 1'b0;
        chk_blk("abort_mem_unchanged", mem[7], saved);
        do_req(2'b00, 7, pack6(1, 2, 3, 4, 5, 6), 1, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbf_block_rmw_engine.md
Name: cbf_block_rmw_engine

Overview:
- Sequential read-modify-write engine for one counting-Bloom-filter block store; successor to the combinational block decoder.
- Per request: reads one block from external block memory, decodes NUM_HASHES entries, and performs one of three operations: query, insert (saturating increment) or delete (saturating decrement, saturated entries sticky).
- For insert/delete, writes the block back before responding.
- Sits between the hash generator and the block RAM; one request in flight.

Parameters:
- NUM_HASHES, 6, hash indices per request
- VECTOR_WIDTH, 1024, CBF entries per block
- NUM_BITS_TO_ADDRESS_VECTOR, 10, bits per hash index
- CBF_WIDTH, 4, bits per entry (1 allowed: plain Bloom bit)
- BLOCK_ADDR_WIDTH, 8, block-memory address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  1  request valid
- reqReady  out  1  engine accepts request
- reqOp  in  2  00 query, 01 insert, 10 delete, 11 treated as query
- reqBlockAddr  in  BLOCK_ADDR_WIDTH  block to operate on
- reqHashes  in  NUM_BITS_TO_ADDRESS_VECTOR*NUM_HASHES  packed indices, hash 0 in LSBs
- memRdEn  out  1  one-cycle read strobe
- memRdAddr  out  BLOCK_ADDR_WIDTH  read address
- memRdValid  in  1  read data valid (arbitrary latency ≥1)
- memRdData  in  CBF_WIDTH*VECTOR_WIDTH  block data
- memWrEn  out  1  one-cycle write strobe
- memWrAddr  out  BLOCK_ADDR_WIDTH  write address
- memWrData  out  CBF_WIDTH*VECTOR_WIDTH  modified block
- respValid  out  1  response valid
- respReady  in  1  response accepted
- respPresent  out  1  all selected entries nonzero (pre-op values)
- respMinCount  out  CBF_WIDTH  minimum of selected entries (pre-op)
- respElements  out  CBF_WIDTH*NUM_HASHES  selected entries (pre-op), packed like reqHashes

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - reqReady=1; memRdEn=0; memWrEn=0; respValid=0.
  - All address/data/response registers are 0.
- FSM states: IDLE, READ, WAIT, COMPUTE, WRITE, RESP.
- IDLE: reqReady=1. On reqValid, latch op/addr/hashes → READ. reqReady=0 in every other state.
- READ: memRdEn=1 and memRdAddr=latched addr for exactly one cycle → WAIT.
- WAIT: hold until memRdValid; capture memRdData → COMPUTE. memRdValid seen in any other state is ignored.
- COMPUTE (one cycle):
  - Register respElements, respMinCount and respPresent from the captured block.
  - Register the modified block.
  - Next state: WRITE if op is insert or delete, else RESP.
- Insert, per entry j (entry is hit if any hash equals j):
  - Hit and entry != all-ones → entry+1; otherwise unchanged.
  - Duplicate hashes increment an entry only once.
- Delete, per hit entry j:
  - Entry in 1..(2^CBF_WIDTH−2) → entry−1.
  - Entry 0 or all-ones (saturated, sticky) → unchanged.
- CBF_WIDTH=1: insert ORs the bit; delete leaves the bit unchanged.
- Query: block unchanged, no write.
- WRITE: memWrEn=1 for exactly one cycle; memWrAddr=latched addr; memWrData=modified block → RESP.
- RESP: respValid=1 and response fields held stable until respReady; then → IDLE.
  - reqReady rises the cycle after the handshake.
  - No combinational path from respReady to reqReady.
- Latency with 1-cycle memory, request accept to respValid:
  - query: 4 cycles
  - insert/delete: 5 cycles
- Response fields always reflect pre-modification values.
- Hash index ≥ VECTOR_WIDTH: selects nothing for modification; the corresponding element reads 0.
- Reset mid-operation: abort immediately and return to IDLE; any pending write is dropped and no response is issued.

Test Plan:
- Reset → reqReady=1, memRdEn=memWrEn=respValid=0.
- Block 5 all zero, insert hashes {3,3,7,0,1,2} → memWrData entries 0,1,2,3,7 =1 (entry 3 not 2), others 0. Response: respPresent=0, respMinCount=0, write precedes respValid.
- Block 5 entry 9=15, entry 4=2; insert then delete with all hashes 9 and 4 → entry 9 stays 15 throughout; entry 4 goes 3 then 2.
- Query block with entries {3,7,0,1,2}=1 via hashes {0,1,2,3,7,7} → respPresent=1, respMinCount=1, no memWrEn pulse, latency 4 cycles with 1-cycle memory.
- Memory latency 5 cycles and respReady held low 3 cycles → respValid and fields stable, reqReady stays 0 until the cycle after the handshake.
- Assert rst_n low while in WAIT during an insert → no memWrEn, no respValid; subsequent query of the same block returns the original data.
